// File: rtl/div_issue_ctrl.sv
// Issue/sequencing control for one RV32M DIV/DIVU/REM/REMU op on an external unsigned divider.
// Optional macro DIV_SPECIAL_BYPASS_EN: divide-by-zero and signed overflow skip the divider entirely.
module div_issue_ctrl #(
   parameter int TAG_W = 6
) (
   input  logic             inst_clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_funct3,
   input  logic [31:0]      op_rs1,
   input  logic [31:0]      op_rs2,
   input  logic [TAG_W-1:0] op_tag,
   input  logic             branch_mispredict,
   output logic             div_start,
   output logic [31:0]      div_a,
   output logic [31:0]      div_b,
   output logic             div_flush,
   input  logic [31:0]      div_quotient,
   input  logic [31:0]      div_remainder,
   input  logic             div_complete,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [TAG_W-1:0] res_tag
);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

   state_t             state_reg;
   state_t             state_next;
   logic               run_reg;
   logic [2:0]         funct3_reg;
   logic [31:0]        rs1_reg;
   logic [31:0]        rs2_reg;
   logic [TAG_W-1:0]   tag_reg;
   logic [31:0]        div_a_reg;
   logic [31:0]        div_b_reg;
   logic [31:0]        res_data_reg;
   logic [TAG_W-1:0]   res_tag_reg;
   logic               capture_div;
   logic               accept;

   function automatic logic [31:0] magnitude(input logic is_signed, input logic [31:0] x);
      return (is_signed && x[31]) ? (32'd0 - x) : x;
   endfunction

   // Turns the divider's unsigned quotient/remainder into the architectural result,
   // substituting the fixed answers for divide-by-zero and signed overflow.
   function automatic logic [31:0] fixup(
      input logic [2:0]  f3,
      input logic [31:0] rs1,
      input logic [31:0] rs2,
      input logic [31:0] q,
      input logic [31:0] r
   );
      logic        is_signed;
      logic        div_zero;
      logic        overflow;
      logic [31:0] q_fix;
      logic [31:0] r_fix;
      is_signed = !f3[0];
      div_zero  = (rs2 == 32'd0);
      overflow  = is_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
      q_fix     = (is_signed && !div_zero && (rs1[31] ^ rs2[31])) ? (32'd0 - q) : q;
      r_fix     = (is_signed && rs1[31]) ? (32'd0 - r) : r;
      if (div_zero) begin
         q_fix = 32'hFFFF_FFFF;
         r_fix = rs1;
      end else if (overflow) begin
         q_fix = 32'h8000_0000;
         r_fix = 32'd0;
      end
      return f3[1] ? r_fix : q_fix;
   endfunction

`ifdef DIV_SPECIAL_BYPASS_EN
   logic special_in;
   assign special_in = (op_rs2 == 32'd0) ||
                       (!op_funct3[0] && (op_rs1 == 32'h8000_0000) && (op_rs2 == 32'hFFFF_FFFF));
`endif

   assign accept = op_valid && op_ready;

   always_comb begin
      state_next  = state_reg;
      capture_div = 1'b0;
      op_ready    = run_reg && (state_reg == IDLE) && !branch_mispredict;
      div_start   = (state_reg == START) && !branch_mispredict;
      div_flush   = branch_mispredict && ((state_reg == START) || (state_reg == WAIT));
      res_valid   = (state_reg == RESULT) && !branch_mispredict;
      case (state_reg)
         IDLE: begin
            if (op_valid && op_ready) begin
`ifdef DIV_SPECIAL_BYPASS_EN
               state_next = special_in ? RESULT : START;
`else
               state_next = START;
`endif
            end
         end
         START, WAIT: begin
            if (branch_mispredict) begin
               state_next = IDLE;
            end else if (div_complete) begin
               state_next  = RESULT;
               capture_div = 1'b1;
            end else begin
               state_next = WAIT;
            end
         end
         RESULT: begin
            if (branch_mispredict || res_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // run_reg keeps op_ready low until the first edge after reset release.
   always_ff @(posedge inst_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         run_reg      <= 1'b0;
         funct3_reg   <= 3'd0;
         rs1_reg      <= 32'd0;
         rs2_reg      <= 32'd0;
         tag_reg      <= '0;
         div_a_reg    <= 32'd0;
         div_b_reg    <= 32'd0;
         res_data_reg <= 32'd0;
         res_tag_reg  <= '0;
      end else begin
         state_reg <= state_next;
         run_reg   <= 1'b1;
         if (accept) begin
            funct3_reg <= op_funct3;
            rs1_reg    <= op_rs1;
            rs2_reg    <= op_rs2;
            tag_reg    <= op_tag;
            div_a_reg  <= magnitude(!op_funct3[0], op_rs1);
            div_b_reg  <= magnitude(!op_funct3[0], op_rs2);
         end
         if (capture_div) begin
            res_data_reg <= fixup(funct3_reg, rs1_reg, rs2_reg, div_quotient, div_remainder);
            res_tag_reg  <= tag_reg;
         end
`ifdef DIV_SPECIAL_BYPASS_EN
         if (accept && special_in) begin
            res_data_reg <= fixup(op_funct3, op_rs1, op_rs2, 32'd0, 32'd0);
            res_tag_reg  <= op_tag;
         end
`endif
      end
   end

   assign div_a    = div_a_reg;
   assign div_b    = div_b_reg;
   assign res_data = res_data_reg;
   assign res_tag  = res_tag_reg;

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 6, ROB tag width.
REQ-002 SHALL have ports: inst_clk in 1, sole clock; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: op_valid in 1, op_ready out 1, op_funct3 in 3 (100 DIV, 101 DIVU, 110 REM, 111 REMU), op_rs1 in 32, op_rs2 in 32, op_tag in TAG_W.
REQ-004 SHALL have ports: branch_mispredict in 1, flush of the in-flight op.
REQ-005 SHALL have divider-side ports: div_start out 1, div_a out 32, div_b out 32, div_flush out 1, div_quotient in 32, div_remainder in 32, div_complete in 1.
REQ-006 SHALL have result ports: res_valid out 1, res_ready in 1, res_data out 32, res_tag out TAG_W.

Function
REQ-007 SHALL implement states IDLE, START, WAIT, RESULT; op_ready = (state==IDLE) && !branch_mispredict.
REQ-008 On op_valid && op_ready, SHALL register funct3, rs1, rs2 and tag, and go IDLE->START.
REQ-009 SHALL form magnitudes for signed ops (funct3[0]==0): |x| = x[31] ? two's-complement negation : x; unsigned ops pass operands unchanged; div_a/div_b are registered magnitudes, stable from START until leaving WAIT.
REQ-010 In START, SHALL assert div_start for exactly one cycle, then go to WAIT; if div_complete is high in START, SHALL go directly to RESULT.
REQ-011 In WAIT, SHALL hold div_start low and go to RESULT on the cycle div_complete is high, capturing div_quotient/div_remainder that cycle.
REQ-012 Sign fixup: quotient negated iff signed op, rs2!=0, and rs1[31]^rs2[31]; remainder negated iff signed op and rs1[31].
REQ-013 Divide-by-zero (rs2==0) SHALL yield quotient 0xFFFFFFFF and remainder = original rs1, independent of divider outputs.
REQ-014 Signed overflow (rs1==0x80000000, rs2==0xFFFFFFFF, DIV/REM) SHALL yield quotient 0x80000000, remainder 0.
REQ-015 res_data SHALL be the quotient for funct3[1]==0, else the remainder, registered on entry to RESULT.
REQ-016 In RESULT, res_valid SHALL be 1 and res_data/res_tag stable until res_valid && res_ready; then go to IDLE.
REQ-017 branch_mispredict in any state SHALL force IDLE at the next edge, drop res_valid, and suppress div_start that cycle.
REQ-018 div_flush SHALL equal branch_mispredict && state in {START, WAIT}.
REQ-019 div_complete outside START/WAIT SHALL be ignored.
REQ-020 Normal-path latency: accept edge to res_valid = 2 + divider cycles; one op in flight maximum.

Reset
REQ-021 While rst_n low: state IDLE, res_valid 0, div_start 0, res_data 0, res_tag 0, captured operands 0; op_ready is low while rst_n is low and high from the first edge after release.
REQ-022 Reset assertion mid-operation SHALL abandon the op asynchronously with no result produced.

Configuration
REQ-023 Macro DIV_SPECIAL_BYPASS_EN defined: divide-by-zero and signed-overflow ops SHALL go IDLE->RESULT directly (res_valid one cycle after accept), never asserting div_start.
REQ-024 Macro undefined: all ops SHALL traverse START/WAIT, with REQ-013/014 results substituted at capture.

Verification
REQ-025 DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> res_data 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-026 DIVU rs1=0x80000000, rs2=0 -> res_data 0xFFFFFFFF; REMU -> 0x80000000; with DIV_SPECIAL_BYPASS_EN, div_start never high.
REQ-027 DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
REQ-028 REMU rs1=100, rs2=7 with res_ready low 5 cycles -> res_valid held, res_data 2 and tag stable, op_ready low until handshake.
REQ-029 branch_mispredict pulsed during WAIT -> div_flush high that cycle, IDLE next edge, no res_valid; a following DIV 20/5 returns 4.
REQ-030 rst_n pulsed low during WAIT -> outputs at reset values immediately; a new op after release completes correctly.
